// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the IF/MEM single-port memory arbiter.
// Latency: n/a (declarations and a pure combinational helper only).
// Backpressure: n/a.
package mem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } arb_state_t;

    localparam logic GRANT_IF  = 1'b0;
    localparam logic GRANT_MEM = 1'b1;

    // Wait counter is sized for the largest supported WAIT_CYCLES (15).
    localparam int CNT_W = $clog2(16);

    // Round-robin pick: on a tie the requester that did not win last time goes.
    function automatic logic pick_grant(input logic if_req,
                                        input logic mem_req,
                                        input logic last_grant);
        if (if_req && mem_req) begin
            return ~last_grant;
        end else if (mem_req) begin
            return GRANT_MEM;
        end else begin
            return GRANT_IF;
        end
    endfunction

endpackage

// File: rtl/mem_wait_counter.sv
// Down-counter timing one memory access: load, decrement, zero flag.
// Latency: load/decrement take effect on the next rising edge; zero is combinational from the count.
// Backpressure: none; decrement saturates at zero.
module mem_wait_counter
    import mem_arb_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             dec,
    output logic             zero
);

    logic [CNT_W-1:0] cnt;

    // Load has priority over decrement; never wrap below zero.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && (cnt != '0)) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign zero = (cnt == '0);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one single-ported memory between IF fetches and MEM loads/stores, round-robin on ties.
// Latency: request sampled at edge k, ext_en high WAIT_CYCLES cycles, ready pulse WAIT_CYCLES+1 cycles after k.
// Backpressure: requesters hold req level; freeze stalls the pipeline until the ready pulse.
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int ADDR_W      = 32,
    parameter int DATA_W      = 32,
    // Legal range 1..15; the wait counter is only CNT_W bits wide.
    parameter int WAIT_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              mem_req,
    input  logic              mem_we,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    output logic [DATA_W-1:0] mem_rdata,
    output logic              mem_ready,
    output logic              ext_en,
    output logic              ext_we,
    output logic [ADDR_W-1:0] ext_addr,
    output logic [DATA_W-1:0] ext_wdata,
    input  logic [DATA_W-1:0] ext_rdata,
    output logic              freeze
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(WAIT_CYCLES - 1);

    arb_state_t state;
    arb_state_t state_nxt;
    logic       grant;
    logic       grant_nxt;
    logic       last_grant;
    logic       start;
    logic       finish;
    logic       cnt_load;
    logic       cnt_dec;
    logic       cnt_zero;

    mem_wait_counter u_wait_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (CNT_INIT),
        .dec      (cnt_dec),
        .zero     (cnt_zero)
    );

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and per-cycle control strobes.
    always_comb begin
        state_nxt = state;
        grant_nxt = grant;
        start     = 1'b0;
        finish    = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        case (state)
            IDLE: begin
                if (if_req || mem_req) begin
                    start     = 1'b1;
                    grant_nxt = pick_grant(if_req, mem_req, last_grant);
                    cnt_load  = 1'b1;
                    state_nxt = ACCESS;
                end
            end
            ACCESS: begin
                if (cnt_zero) begin
                    finish    = 1'b1;
                    state_nxt = RESP;
                end else begin
                    cnt_dec = 1'b1;
                end
            end
            RESP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Latch the granted request into the memory port, then capture read data and pulse ready.
    // Requester inputs are only looked at on the grant edge, so mid-access changes are ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            grant      <= GRANT_IF;
            last_grant <= GRANT_IF;
            ext_en     <= 1'b0;
            ext_we     <= 1'b0;
            ext_addr   <= '0;
            ext_wdata  <= '0;
            if_rdata   <= '0;
            mem_rdata  <= '0;
            if_ready   <= 1'b0;
            mem_ready  <= 1'b0;
        end else begin
            if_ready  <= 1'b0;
            mem_ready <= 1'b0;
            if (start) begin
                grant  <= grant_nxt;
                ext_en <= 1'b1;
                if (grant_nxt == GRANT_MEM) begin
                    ext_we    <= mem_we;
                    ext_addr  <= mem_addr;
                    ext_wdata <= mem_wdata;
                end else begin
                    ext_we    <= 1'b0;
                    ext_addr  <= if_addr;
                    ext_wdata <= '0;
                end
            end
            if (finish) begin
                ext_en     <= 1'b0;
                ext_we     <= 1'b0;
                last_grant <= grant;
                if (grant == GRANT_MEM) begin
                    mem_ready <= 1'b1;
                    // Stores leave the previous load data in place.
                    if (!ext_we) begin
                        mem_rdata <= ext_rdata;
                    end
                end else begin
                    if_ready <= 1'b1;
                    if_rdata <= ext_rdata;
                end
            end
        end
    end

    assign freeze = (if_req & ~if_ready) | (mem_req & ~mem_ready);

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported instruction/data memory between the IF stage (fetch reads) and the MEM stage (loads/stores).
- Each access runs for a fixed number of wait cycles.
- While a requester's access is pending, the block produces a pipeline-freeze indication.
- Sits between IF_Stage/Mem_Stage and the external memory model; feeds the existing Freeze net together with the hazard unit.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, data width
WAIT_CYCLES, 2, memory access cycles per transaction; legal range 1..15

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  reset; one clock, asynchronous assert, active-low (0 = reset)
if_req  input  1  IF fetch request, level
if_addr  input  ADDR_W  fetch address
if_rdata  output  DATA_W  fetched word, valid while if_ready=1
if_ready  output  1  one-cycle completion pulse for IF
mem_req  input  1  MEM stage request, level
mem_we  input  1  1 = store, 0 = load
mem_addr  input  ADDR_W  load/store address
mem_wdata  input  DATA_W  store data
mem_rdata  output  DATA_W  load data, valid while mem_ready=1
mem_ready  output  1  one-cycle completion pulse for MEM
ext_en  output  1  memory access enable
ext_we  output  1  memory write enable
ext_addr  output  ADDR_W  memory address
ext_wdata  output  DATA_W  memory write data
ext_rdata  input  DATA_W  memory read data, valid in the last ACCESS cycle
freeze  output  1  (if_req & ~if_ready) | (mem_req & ~mem_ready)

Behaviour:
- FSM states: IDLE, ACCESS, RESP. All registers are reset asynchronously when rst=0:
  - state=IDLE, cnt=0, grant=IF, last_grant=IF.
  - ext_en=0, ext_we=0, ext_addr=0, ext_wdata=0.
  - if_rdata=0, mem_rdata=0, if_ready=0, mem_ready=0.
- IDLE:
  - No request: stay in IDLE.
  - One request: grant it.
  - Both requests: grant the requester not equal to last_grant (round-robin). After reset, MEM wins the first tie.
  - On the grant edge:
    - Latch address, we and wdata of the granted requester into ext_* registers; ext_we=0 for IF.
    - Set ext_en=1 and cnt=WAIT_CYCLES-1; go to ACCESS.
- ACCESS:
  - ext_* outputs are held stable. Requester inputs are ignored (latched copy is used).
  - cnt decrements each cycle. When cnt==0:
    - Capture ext_rdata into if_rdata or mem_rdata (for the granted requester, loads/fetches only; stores leave mem_rdata unchanged).
    - Clear ext_en and ext_we; set last_grant=grant; go to RESP.
- RESP: exactly one cycle. The ready of the granted requester is 1, the other ready is 0. Go to IDLE.
- Latency: request sampled at edge k → ext_en high for WAIT_CYCLES cycles → ready high in cycle k+WAIT_CYCLES+1. There is one IDLE bubble minimum between transactions.
- ready pulses are registered outputs. rdata holds its value until the next capture for that requester.
- Request withdrawn mid-ACCESS (branch flush):
  - The transaction still completes, writes are not cancelled, and the ready pulse is still issued.
  - The requester discards it.
- Request held high in RESP is treated as a new request in the following IDLE cycle.
- A requester's address/data changing during ACCESS has no effect on the ext_* outputs.
- Reset asserted mid-ACCESS: ext_en and ext_we drop immediately (asynchronously) and no ready pulse is produced.
- freeze is combinational from inputs and registered readies. No other combinational input-to-output paths.

Decomposition:
- Shared package (mem_arb_pkg):
  - State encoding constants: IDLE=2'd0, ACCESS=2'd1, RESP=2'd2.
  - Grant constants: GRANT_IF=1'b0, GRANT_MEM=1'b1.
- One sub-module: mem_wait_counter (load/decrement/zero-flag, width $clog2(16)=4, async active-low reset).

Test Plan:
- IF only, WAIT_CYCLES=2, if_addr=0x10, ext_rdata=0xDEADBEEF in last ACCESS cycle → ext_en high exactly 2 cycles with ext_addr=0x10 and ext_we=0; if_ready single pulse 3 cycles after request; if_rdata=0xDEADBEEF; freeze=1 until then.
- MEM store mem_addr=0x40, mem_wdata=0x12345678 → ext_we=1, ext_wdata=0x12345678 for 2 cycles; mem_ready pulse; mem_rdata unchanged.
- if_req and mem_req both high from reset → MEM served first, then IF. Keep both asserted → grants alternate MEM, IF, MEM… with no starvation.
- if_req dropped and if_addr changed to 0x99 mid-ACCESS → ext_addr stays at original address; if_ready still pulses once; next IDLE samples the new request only if if_req=1.
- rst driven low during ACCESS → ext_en/ext_we 0 in same cycle (no clock edge); after release, state IDLE; no ready pulse emitted.
- WAIT_CYCLES=1 rerun of the first scenario → ext_en high 1 cycle; if_ready 2 cycles after request.
